// File: rtl/bias_feeder.sv
// bias_feeder: stores up to DEPTH bias rows loaded from the host side and
// replays them, one per array output row, to the bias-add stage.
module bias_feeder #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 64,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              load_start,
  input  logic [CNT_W-1:0]  num_rows,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_done,
  input  logic              array_valid,
  output logic [DATA_W-1:0] bias,
  output logic              bias_valid,
  output logic [CNT_W-1:0]  rd_idx,
  output logic              underrun
);

  localparam int               AW      = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  rows_q, wr_ptr_q, rd_ptr_q;
  logic              load_done_q, underrun_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              start_ok, wr_fire, wr_last, rd_fire, rd_last;
  logic [CNT_W-1:0]  rows_clamp;

  // A zero-row load is meaningless and is ignored in every state; a restart
  // inside LOAD drops the beat presented in the same cycle.
  assign start_ok   = load_start && (num_rows != '0);
  assign rows_clamp = (num_rows > DEPTH_C) ? DEPTH_C : num_rows;
  assign wr_fire    = (state_q == LOAD) && load_valid && !start_ok;
  assign wr_last    = wr_fire && (wr_ptr_q == rows_q - ONE);
  assign rd_fire    = (state_q == READY) && array_valid;
  assign rd_last    = (rd_ptr_q == rows_q - ONE);

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and Moore/combinational outputs
  always_comb begin
    state_d    = state_q;
    load_ready = 1'b0;
    bias_valid = 1'b0;
    bias       = '0;
    case (state_q)
      IDLE: begin
        if (start_ok) state_d = LOAD;
      end
      LOAD: begin
        load_ready = 1'b1;
        if (start_ok)     state_d = LOAD;
        else if (wr_last) state_d = READY;
      end
      READY: begin
        // Row served this cycle uses the current set even if a reload starts.
        bias       = mem[rd_ptr_q[AW-1:0]];
        bias_valid = array_valid;
        if (start_ok) state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  // Row count, pointers, done pulse and sticky underrun flag
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rows_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      load_done_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      load_done_q <= wr_last;
      if (start_ok) begin
        rows_q   <= rows_clamp;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (wr_fire) wr_ptr_q <= wr_ptr_q + ONE;
        if (wr_last) rd_ptr_q <= '0;
        else if (rd_fire) rd_ptr_q <= rd_last ? '0 : rd_ptr_q + ONE;
      end
      // An unserved array row is reported even if a load starts alongside it.
      if (array_valid && (state_q != READY)) underrun_q <= 1'b1;
      else if (start_ok)                     underrun_q <= 1'b0;
    end
  end

  // Bias storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr_q[AW-1:0]] <= load_data;
  end

  assign load_done = load_done_q;
  assign underrun  = underrun_q;
  assign rd_idx    = rd_ptr_q;

endmodule

// File: tb/tb_bias_feeder.sv
// tb_bias_feeder: vector table for the basic load/wrap flow, hand sequences
// for the multi-cycle corners, and a randomized run against a row-set model.
module tb_bias_feeder;
  localparam int DEPTH = 8, DATA_W = 64, CNT_W = 4;

  logic              clk = 1'b0, n_rst;
  logic              load_start, load_valid, array_valid;
  logic [CNT_W-1:0]  num_rows;
  logic [DATA_W-1:0] load_data;
  logic              load_ready, load_done, bias_valid, underrun;
  logic [DATA_W-1:0] bias;
  logic [CNT_W-1:0]  rd_idx;

  int checks = 0, passed = 0;

  bias_feeder #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .n_rst(n_rst), .load_start(load_start), .num_rows(num_rows),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .load_done(load_done), .array_valid(array_valid), .bias(bias),
    .bias_valid(bias_valid), .rd_idx(rd_idx), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic ls, input logic [3:0] n, input logic lv,
                       input logic [63:0] d, input logic av);
    load_start = ls; num_rows = n; load_valid = lv; load_data = d; array_valid = av;
  endtask

  // Inputs change at posedge+1, outputs are sampled at posedge+4.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
  endtask

  // ---------------- reference model: a stored row set and a read cursor ----
  bit          m_loading, m_have_set, m_under, m_done;
  int          m_rows, m_wr, m_rd;
  logic [63:0] m_mem [DEPTH];

  task automatic model_reset();
    m_loading = 0; m_have_set = 0; m_under = 0; m_done = 0;
    m_rows = 0; m_wr = 0; m_rd = 0;
  endtask

  task automatic model_step();
    bit go;
    go = load_start && (num_rows != 0);
    m_done = 0;
    if (array_valid && !m_have_set) m_under = 1;
    else if (go) m_under = 0;
    if (go) begin
      m_loading = 1; m_have_set = 0; m_wr = 0; m_rd = 0;
      m_rows = (int'(num_rows) > DEPTH) ? DEPTH : int'(num_rows);
    end else if (m_loading && load_valid) begin
      m_mem[m_wr] = load_data;
      m_wr++;
      if (m_wr == m_rows) begin
        m_loading = 0; m_have_set = 1; m_rd = 0; m_done = 1;
      end
    end else if (m_have_set && array_valid) begin
      m_rd = (m_rd + 1) % m_rows;
    end
  endtask

  // ---------------- vector table ------------------------------------------
  typedef struct {
    logic ls; logic [3:0] n; logic lv; logic [63:0] d; logic av;
    logic rdy; logic done; logic bv; logic [63:0] bias; logic [3:0] rd; logic und;
  } vec_t;

  vec_t        tbl [13];
  logic [63:0] pat [3];
  logic [63:0] rs;

  initial begin
    pat[0] = 64'h0101010101010101;
    pat[1] = 64'h0202020202020202;
    pat[2] = 64'hFFFFFFFFFFFFFFFF;
    tbl[0] = '{1'b1, 4'd3, 1'b0, 64'd0,  1'b0, 1'b0, 1'b0, 1'b0, 64'd0,  4'd0, 1'b0};
    tbl[1] = '{1'b0, 4'd0, 1'b1, pat[0], 1'b0, 1'b1, 1'b0, 1'b0, 64'd0,  4'd0, 1'b0};
    tbl[2] = '{1'b0, 4'd0, 1'b1, pat[1], 1'b0, 1'b1, 1'b0, 1'b0, 64'd0,  4'd0, 1'b0};
    tbl[3] = '{1'b0, 4'd0, 1'b1, pat[2], 1'b0, 1'b1, 1'b0, 1'b0, 64'd0,  4'd0, 1'b0};
    tbl[4] = '{1'b0, 4'd0, 1'b0, 64'd0,  1'b0, 1'b0, 1'b1, 1'b0, pat[0], 4'd0, 1'b0};
    for (int k = 0; k < 7; k++)
      tbl[5+k] = '{1'b0, 4'd0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b1, pat[k%3], 4'(k%3), 1'b0};
    tbl[12] = '{1'b0, 4'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, pat[1], 4'd1, 1'b0};

    n_rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    do_reset();
    #3;
    chk("reset ready", 64'(load_ready), 0);
    chk("reset done",  64'(load_done), 0);
    chk("reset bv",    64'(bias_valid), 0);
    chk("reset bias",  bias, 0);
    chk("reset rd",    64'(rd_idx), 0);
    chk("reset und",   64'(underrun), 0);
    tick();

    // Load 3 rows, then wrap over them
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].ls, tbl[i].n, tbl[i].lv, tbl[i].d, tbl[i].av);
      #3;
      chk($sformatf("vec%0d ready", i), 64'(load_ready), 64'(tbl[i].rdy));
      chk($sformatf("vec%0d done", i),  64'(load_done),  64'(tbl[i].done));
      chk($sformatf("vec%0d bv", i),    64'(bias_valid), 64'(tbl[i].bv));
      chk($sformatf("vec%0d bias", i),  bias,            tbl[i].bias);
      chk($sformatf("vec%0d rd", i),    64'(rd_idx),     64'(tbl[i].rd));
      chk($sformatf("vec%0d und", i),   64'(underrun),   64'(tbl[i].und));
      tick();
    end

    // Underrun before any load, cleared by an accepted load_start
    do_reset();
    drive(0, 0, 0, 0, 1); #3;
    chk("und bv", 64'(bias_valid), 0);
    chk("und bias", bias, 0);
    tick();
    drive(0, 0, 0, 0, 0); #3;
    chk("und set", 64'(underrun), 1); tick();
    drive(1, 0, 0, 0, 0); #3;
    chk("und held", 64'(underrun), 1); tick();
    drive(1, 2, 0, 0, 0); #3;
    chk("und still", 64'(underrun), 1); tick();
    drive(0, 0, 0, 0, 0); #3;
    chk("und cleared", 64'(underrun), 0);
    chk("und load", 64'(load_ready), 1);
    tick();

    // Clamp num_rows=12 to DEPTH, restart after 4 beats
    do_reset();
    drive(1, 12, 0, 0, 0); #3; tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 64'hAAAA_0000_0000_0000 + 64'(i), 0); #3;
      chk($sformatf("clamp pre%0d ready", i), 64'(load_ready), 1); tick();
    end
    drive(1, 12, 1, 64'hDEAD_BEEF_DEAD_BEEF, 0); #3;
    chk("restart ready", 64'(load_ready), 1); tick();
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 1, 64'h1111111111111111 * 64'(i + 1), 0); #3;
      chk($sformatf("clamp beat%0d ready", i), 64'(load_ready), 1);
      chk($sformatf("clamp beat%0d done", i), 64'(load_done), 0);
      tick();
    end
    drive(0, 0, 0, 0, 0); #3;
    chk("clamp done", 64'(load_done), 1);
    chk("clamp ready", 64'(load_ready), 0);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 0, 1); #3;
      rs = 64'h1111111111111111 * 64'(i + 1);
      chk($sformatf("clamp row%0d", i), bias, rs);
      chk($sformatf("clamp rd%0d", i), 64'(rd_idx), 64'(i));
      tick();
    end

    // Reload while serving row 1
    drive(0, 0, 0, 0, 1); #3; tick();
    drive(1, 1, 0, 0, 1); #3;
    chk("reload old row", bias, 64'h2222222222222222);
    chk("reload old bv", 64'(bias_valid), 1);
    chk("reload rd", 64'(rd_idx), 1);
    tick();
    drive(0, 0, 1, 64'h3838383838383838, 1); #3;
    chk("reload load", 64'(load_ready), 1);
    chk("reload bv0", 64'(bias_valid), 0);
    chk("reload bias0", bias, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1); #3;
      chk($sformatf("single row%0d", i), bias, 64'h3838383838383838);
      chk($sformatf("single rd%0d", i), 64'(rd_idx), 0);
      chk($sformatf("single bv%0d", i), 64'(bias_valid), 1);
      tick();
    end

    // Asynchronous reset mid-load
    do_reset();
    drive(1, 4, 0, 0, 0); #3; tick();
    for (int i = 0; i < 2; i++) begin drive(0, 0, 1, 64'(i + 5), 0); #3; tick(); end
    drive(0, 0, 1, 64'h77, 0);
    #2 n_rst = 1'b0;
    #1;
    chk("arst ready", 64'(load_ready), 0);
    chk("arst rd", 64'(rd_idx), 0);
    chk("arst bias", bias, 0);
    @(posedge clk); #1 n_rst = 1'b1;
    drive(0, 0, 0, 0, 1); #3;
    chk("arst bv", 64'(bias_valid), 0);
    chk("arst und0", 64'(underrun), 0);
    tick();
    drive(0, 0, 0, 0, 0); #3;
    chk("arst und1", 64'(underrun), 1);
    tick();

    // Randomized run against the model
    do_reset();
    model_reset();
    for (int c = 0; c < 500; c++) begin
      drive($urandom_range(0, 14) == 0, 4'($urandom_range(0, 15)),
            $urandom_range(0, 3) != 0, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      #3;
      chk($sformatf("rnd%0d ready", c), 64'(load_ready), 64'(m_loading));
      chk($sformatf("rnd%0d done", c),  64'(load_done),  64'(m_done));
      chk($sformatf("rnd%0d bv", c),    64'(bias_valid), 64'(m_have_set && array_valid));
      chk($sformatf("rnd%0d bias", c),  bias,            m_have_set ? m_mem[m_rd] : 64'd0);
      chk($sformatf("rnd%0d rd", c),    64'(rd_idx),     64'(m_rd));
      chk($sformatf("rnd%0d und", c),   64'(underrun),   64'(m_under));
      model_step();
      tick();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
